// File: rtl/insts_fetch_buffer_pkg.sv
// Shared parameters and entry layout for the instruction fetch buffer.
package insts_fetch_buffer_pkg;

    localparam int unsigned INSTS_FETCH_WIDTH_IN_BITS = 128;
    localparam int unsigned CPU_WORD_LEN_IN_BITS      = 64;
    localparam int unsigned INST_LEN_IN_BITS          = 32;
    localparam int unsigned FETCH_BUFFER_DEPTH        = 4;

    localparam int unsigned INSTS_PER_PACKET = INSTS_FETCH_WIDTH_IN_BITS / INST_LEN_IN_BITS;
    localparam int unsigned SLOT_W           = $clog2(INSTS_PER_PACKET);
    // PC bits below the packet boundary: slot index plus the 4-byte instruction offset
    localparam int unsigned PC_LO_W          = SLOT_W + 2;
    localparam int unsigned PC_HI_W          = CPU_WORD_LEN_IN_BITS - PC_LO_W;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef struct packed {
        logic [PC_HI_W-1:0]                   pc_hi;
        slot_t                                start_slot;
        logic [INSTS_FETCH_WIDTH_IN_BITS-1:0] packet;
    } fb_entry_t;

    localparam int unsigned ENTRY_W = $bits(fb_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count, full/empty and a flush that clears all pointers.
module sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Flush wins over any same-cycle write or read
    assign do_push = wr_en & ~full  & ~flush;
    assign do_pop  = rd_en & ~empty & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is qualified by count, so it carries no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/insts_fetch_buffer.sv
// Buffers fetch packets and hands them to the decoder one instruction per cycle,
// starting each packet at the slot selected by its PC.
module insts_fetch_buffer #(
    parameter int unsigned INSTS_FETCH_WIDTH_IN_BITS = insts_fetch_buffer_pkg::INSTS_FETCH_WIDTH_IN_BITS,
    parameter int unsigned CPU_WORD_LEN_IN_BITS      = insts_fetch_buffer_pkg::CPU_WORD_LEN_IN_BITS,
    parameter int unsigned FETCH_BUFFER_DEPTH        = insts_fetch_buffer_pkg::FETCH_BUFFER_DEPTH
) (
    input  logic                                                clk_in,
    input  logic                                                reset_in,
    input  logic [INSTS_FETCH_WIDTH_IN_BITS-1:0]                packet_in,
    input  logic [CPU_WORD_LEN_IN_BITS-1:0]                     packet_pc_in,
    input  logic                                                packet_valid_in,
    output logic                                                packet_ready_out,
    input  logic                                                flush_in,
    output logic [insts_fetch_buffer_pkg::INST_LEN_IN_BITS-1:0] inst_out,
    output logic [CPU_WORD_LEN_IN_BITS-1:0]                     inst_pc_out,
    output logic                                                inst_valid_out,
    input  logic                                                inst_ready_in,
    output logic [$clog2(FETCH_BUFFER_DEPTH+1)-1:0]             count_out
);

    import insts_fetch_buffer_pkg::*;

    localparam int unsigned CNT_W  = $clog2(FETCH_BUFFER_DEPTH + 1);
    localparam int unsigned INST_W = INST_LEN_IN_BITS;

    fb_entry_t        wr_entry;
    fb_entry_t        head_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             push;
    logic             pop;
    logic             free_head;
    slot_t            slot_q, slot_d;
    slot_t            slot_c;
    logic             head_fresh_q, head_fresh_d;
    logic             unused_pc_lsbs;

    assign wr_entry.pc_hi      = packet_pc_in[CPU_WORD_LEN_IN_BITS-1:PC_LO_W];
    assign wr_entry.start_slot = packet_pc_in[PC_LO_W-1:2];
    assign wr_entry.packet     = packet_in;
    assign unused_pc_lsbs      = ^packet_pc_in[1:0];

    // Ready ignores a same-cycle pop so a full buffer never takes a packet
    assign packet_ready_out = reset_in & ~fifo_full;
    assign push             = packet_valid_in & packet_ready_out;

    assign inst_valid_out = ~fifo_empty & ~flush_in;
    assign pop            = inst_valid_out & inst_ready_in;

    // A freshly promoted head has not been consumed yet, so its own start slot applies
    assign slot_c    = head_fresh_q ? head_entry.start_slot : slot_q;
    assign free_head = pop & (slot_c == slot_t'(INSTS_PER_PACKET - 1));

    always_comb begin
        slot_d       = slot_q;
        head_fresh_d = head_fresh_q;
        if (flush_in) begin
            slot_d       = '0;
            head_fresh_d = 1'b1;
        end else if (pop) begin
            slot_d       = slot_c + slot_t'(1);
            head_fresh_d = free_head;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            slot_q       <= '0;
            head_fresh_q <= 1'b1;
        end else begin
            slot_q       <= slot_d;
            head_fresh_q <= head_fresh_d;
        end
    end

    // Head instruction select; forced to zero while nothing is buffered
    always_comb begin
        inst_out    = '0;
        inst_pc_out = '0;
        if (!fifo_empty) begin
            inst_out    = head_entry.packet[INST_W * 32'(slot_c) +: INST_W];
            inst_pc_out = {head_entry.pc_hi, slot_c, 2'b00};
        end
    end

    sync_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (FETCH_BUFFER_DEPTH)
    ) u_fifo (
        .clk     (clk_in),
        .rst_n   (reset_in),
        .flush   (flush_in),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (free_head),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign count_out = fifo_count;

endmodule

// File: tb/tb_insts_fetch_buffer.sv
// Scoreboard bench for insts_fetch_buffer: stimulus queues expected instructions,
// a negedge monitor checks every accepted instruction and stall stability.
module tb_insts_fetch_buffer;

    logic         clk_in = 1'b0;
    logic         reset_in;
    logic [127:0] packet_in;
    logic [63:0]  packet_pc_in;
    logic         packet_valid_in;
    logic         packet_ready_out;
    logic         flush_in;
    logic [31:0]  inst_out;
    logic [63:0]  inst_pc_out;
    logic         inst_valid_out;
    logic         inst_ready_in;
    logic [2:0]   count_out;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_inst;
    logic [63:0] stall_pc;
    bit          pushes_done;

    insts_fetch_buffer dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .packet_in        (packet_in),
        .packet_pc_in     (packet_pc_in),
        .packet_valid_in  (packet_valid_in),
        .packet_ready_out (packet_ready_out),
        .flush_in         (flush_in),
        .inst_out         (inst_out),
        .inst_pc_out      (inst_pc_out),
        .inst_valid_out   (inst_valid_out),
        .inst_ready_in    (inst_ready_in),
        .count_out        (count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mk(input int i);
        logic [31:0] b;
        b = 32'hA000_0000 | (32'(i) << 8);
        return {b | 32'd3, b | 32'd2, b | 32'd1, b};
    endfunction

    // Drive one packet for one edge; queue the instructions it should yield if accepted
    task automatic push_pkt(input logic [127:0] pkt, input logic [63:0] pc, input bit accept);
        exp_t e;
        packet_in       = pkt;
        packet_pc_in    = pc;
        packet_valid_in = 1'b1;
        if (accept) begin
            for (int s = int'(pc[3:2]); s < 4; s++) begin
                e.inst = pkt[s*32 +: 32];
                e.pc   = {pc[63:4], 2'(s), 2'b00};
                exp_q.push_back(e);
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk_in);
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare accepted instructions in order, and hold-stability while stalled
    always @(negedge clk_in) begin
        if (inst_valid_out) begin
            if (stall_prev) begin
                check("stall_inst_stable", 64'(inst_out), 64'(stall_inst));
                check("stall_pc_stable", inst_pc_out, stall_pc);
            end
            if (inst_ready_in) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_inst: got 0x%0h @0x%0h expected none (t=%0t)",
                             inst_out, inst_pc_out, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("inst", 64'(inst_out), 64'(mon_e.inst));
                    check("inst_pc", inst_pc_out, mon_e.pc);
                end
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                stall_inst = inst_out;
                stall_pc   = inst_pc_out;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_in        = 1'b1;
        packet_in       = '0;
        packet_pc_in    = '0;
        packet_valid_in = 1'b0;
        flush_in        = 1'b0;
        inst_ready_in   = 1'b0;
        #1 reset_in = 1'b0;
        #2;
        check("rst_count", 64'(count_out), 64'd0);
        check("rst_valid", 64'(inst_valid_out), 64'd0);
        check("rst_ready", 64'(packet_ready_out), 64'd0);
        check("rst_inst", 64'(inst_out), 64'd0);
        check("rst_pc", inst_pc_out, 64'd0);
        @(posedge clk_in);
        #8 reset_in = 1'b1;
        #1;
        check("post_rst_ready", 64'(packet_ready_out), 64'd1);
        next_cycle();

        // Aligned packet: four instructions back to back
        inst_ready_in = 1'b1;
        push_pkt(128'h44444444_33333333_22222222_11111111, 64'h1000, 1'b1);
        packet_valid_in = 1'b0;
        @(negedge clk_in);
        check("first_latency_valid", 64'(inst_valid_out), 64'd1);
        wait_drain("drain_aligned");
        @(negedge clk_in);
        check("aligned_done_valid", 64'(inst_valid_out), 64'd0);
        check("aligned_done_count", 64'(count_out), 64'd0);

        // Mid-packet start slot
        next_cycle();
        push_pkt(128'h44444444_33333333_22222222_11111111, 64'h2008, 1'b1);
        packet_valid_in = 1'b0;
        wait_drain("drain_offset");
        check("offset_done_count", 64'(count_out), 64'd0);

        // Overflow: five packets with the decoder stalled
        next_cycle();
        inst_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_pkt(mk(i), 64'h3000 + 64'(i * 16), i < 4);
            if (i == 3) begin
                check("full_count", 64'(count_out), 64'd4);
                check("full_ready", 64'(packet_ready_out), 64'd0);
            end
        end
        packet_valid_in = 1'b0;
        check("overflow_count", 64'(count_out), 64'd4);
        inst_ready_in = 1'b1;
        wait_drain("drain_overflow");

        // Flush on a full buffer with push and pop requested together
        next_cycle();
        inst_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) push_pkt(mk(10 + i), 64'h7000 + 64'(i * 16), 1'b1);
        flush_in        = 1'b1;
        packet_in       = mk(20);
        packet_pc_in    = 64'h7100;
        packet_valid_in = 1'b1;
        inst_ready_in   = 1'b1;
        exp_q.delete();
        @(negedge clk_in);
        check("flush_cycle_valid", 64'(inst_valid_out), 64'd0);
        next_cycle();
        flush_in        = 1'b0;
        packet_valid_in = 1'b0;
        check("flush_count", 64'(count_out), 64'd0);
        check("flush_valid", 64'(inst_valid_out), 64'd0);

        // Flush beats a push into a non-full buffer
        inst_ready_in = 1'b0;
        push_pkt(mk(30), 64'h8000, 1'b1);
        flush_in = 1'b1;
        exp_q.delete();
        push_pkt(mk(31), 64'h8010, 1'b0);
        flush_in        = 1'b0;
        packet_valid_in = 1'b0;
        check("flush_push_count", 64'(count_out), 64'd0);
        inst_ready_in = 1'b1;
        repeat (4) next_cycle();
        check("flush_push_valid", 64'(inst_valid_out), 64'd0);

        // Streaming with decoder ready pattern 1,0,0,1
        pushes_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) push_pkt(mk(40 + i), 64'h9000 + 64'(i * 16), 1'b1);
                packet_valid_in = 1'b0;
                pushes_done     = 1'b1;
            end
            begin
                logic [3:0] pat;
                pat = 4'b1001;
                for (int c = 0; c < 300; c++) begin
                    inst_ready_in = pat[c % 4];
                    @(posedge clk_in);
                    #1;
                    if (pushes_done && exp_q.size() == 0) break;
                end
            end
        join
        check("stream_left", 64'(exp_q.size()), 64'd0);
        inst_ready_in = 1'b1;
        next_cycle();
        check("stream_count", 64'(count_out), 64'd0);

        // Asynchronous reset mid-stream, then recovery
        push_pkt(mk(50), 64'h5000, 1'b1);
        packet_valid_in = 1'b0;
        @(posedge clk_in);
        #3;
        reset_in = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_count", 64'(count_out), 64'd0);
        check("async_rst_valid", 64'(inst_valid_out), 64'd0);
        check("async_rst_ready", 64'(packet_ready_out), 64'd0);
        check("async_rst_inst", 64'(inst_out), 64'd0);
        check("async_rst_pc", inst_pc_out, 64'd0);
        repeat (2) @(posedge clk_in);
        #3 reset_in = 1'b1;
        next_cycle();
        push_pkt(mk(60), 64'h6004, 1'b1);
        packet_valid_in = 1'b0;
        wait_drain("drain_after_reset");
        @(negedge clk_in);
        check("final_valid", 64'(inst_valid_out), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
